// File: rtl/frame_sync_if.sv
// Serial-data / counter / status bundle between the frame-sync controller
// and its environment (bit source, external counter_n, frame parser).
interface frame_sync_if #(
  parameter int FRAME_LEN = 16
);
  localparam int CW = $clog2(FRAME_LEN);

  logic          din;
  logic          din_vld;
  logic [CW-1:0] cnt_count;
  logic          cnt_sclr;
  logic          cnt_ce;
  logic          locked;
  logic          frame_start;
  logic          sync_err;

  // Environment side: supplies bits and the counter value, consumes strobes.
  modport master (
    output din, din_vld, cnt_count,
    input  cnt_sclr, cnt_ce, locked, frame_start, sync_err
  );

  // Controller side.
  modport slave (
    input  din, din_vld, cnt_count,
    output cnt_sclr, cnt_ce, locked, frame_start, sync_err
  );
endinterface

// File: rtl/frame_sync_ctrl.sv
// Frame-alignment controller: hunts the serial stream for SYNC_WORD, steers
// an external modulo-FRAME_LEN counter through SCLR/CE, qualifies lock over
// LOCK_CNT on-time sync words and drops lock after MISS_CNT misses.
module frame_sync_ctrl #(
  parameter int          FRAME_LEN = 16,
  parameter int          SYNC_W    = 8,
  parameter logic [SYNC_W-1:0] SYNC_WORD = 8'hA7,
  parameter int          LOCK_CNT  = 3,
  parameter int          MISS_CNT  = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  frame_sync_if.slave bus
);
  localparam int CW = $clog2(FRAME_LEN);
  localparam int FW = $clog2(SYNC_W);
  localparam int HW = $clog2(LOCK_CNT + 1);
  localparam int MW = $clog2(MISS_CNT + 1);

  typedef enum logic [1:0] {S_HUNT, S_VERIFY, S_LOCK} state_t;

  state_t          r_state;
  logic [SYNC_W-1:0] r_sr;
  logic [FW-1:0]   r_fill_cnt;
  logic [HW-1:0]   r_hit;
  logic [MW-1:0]   r_miss;
  logic            r_locked;
  logic            r_fs;
  logic            r_se;

  logic [SYNC_W-1:0] w_shift;
  logic            w_fill_ok;
  logic            w_match;
  logic            w_check;
  logic [HW-1:0]   w_hit_nxt;
  logic [MW-1:0]   w_miss_nxt;

  // Candidate window includes the bit arriving this cycle, so a sync word is
  // recognised on the same edge that samples its last bit.
  assign w_shift    = {r_sr[SYNC_W-2:0], bus.din};
  assign w_fill_ok  = (r_fill_cnt == FW'(SYNC_W - 1));
  assign w_match    = bus.din_vld & (w_shift == SYNC_WORD) & w_fill_ok;
  // Counter sits at FRAME_LEN-1 on the last bit of the expected sync word.
  assign w_check    = bus.din_vld & (bus.cnt_count == CW'(FRAME_LEN - 1));
  assign w_hit_nxt  = r_hit + HW'(1);
  assign w_miss_nxt = r_miss + MW'(1);

  // Counter control is combinational so HUNT holds the counter at zero and
  // the match edge itself leaves the counter cleared.
  assign bus.cnt_sclr    = (r_state == S_HUNT);
  assign bus.cnt_ce      = bus.din_vld & (r_state != S_HUNT);
  assign bus.locked      = r_locked;
  assign bus.frame_start = r_fs;
  assign bus.sync_err    = r_se;

  // Shift register, fill tracking, hunt/verify/lock sequencing and strobes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_HUNT;
      r_sr       <= '0;
      r_fill_cnt <= '0;
      r_hit      <= '0;
      r_miss     <= '0;
      r_locked   <= 1'b0;
      r_fs       <= 1'b0;
      r_se       <= 1'b0;
    end else begin
      r_fs <= 1'b0;
      r_se <= 1'b0;
      if (bus.din_vld) begin
        r_sr <= w_shift;
        if (!w_fill_ok) r_fill_cnt <= r_fill_cnt + FW'(1);
        case (r_state)
          S_HUNT: begin
            if (w_match) begin
              if (LOCK_CNT == 1) begin
                r_state  <= S_LOCK;
                r_locked <= 1'b1;
                r_miss   <= '0;
                r_fs     <= 1'b1;
              end else begin
                r_state <= S_VERIFY;
              end
              r_hit <= HW'(1);
            end
          end
          S_VERIFY: begin
            // Off-checkpoint matches are ignored; only the wrap point decides.
            if (w_check) begin
              if (w_match) begin
                r_hit <= w_hit_nxt;
                if (w_hit_nxt == HW'(LOCK_CNT)) begin
                  r_state  <= S_LOCK;
                  r_locked <= 1'b1;
                  r_miss   <= '0;
                  r_fs     <= 1'b1;
                end
              end else begin
                r_state <= S_HUNT;
                r_hit   <= '0;
              end
            end
          end
          S_LOCK: begin
            // Flywheel: the counter keeps wrapping through misses.
            if (w_check) begin
              if (w_match) begin
                r_miss <= '0;
                r_fs   <= 1'b1;
              end else begin
                r_se <= 1'b1;
                if (w_miss_nxt == MW'(MISS_CNT)) begin
                  r_state  <= S_HUNT;
                  r_locked <= 1'b0;
                  r_hit    <= '0;
                  r_miss   <= '0;
                end else begin
                  r_miss <= w_miss_nxt;
                  r_fs   <= 1'b1;
                end
              end
            end
          end
          default: r_state <= S_HUNT;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_frame_sync_ctrl.sv
// Bench for frame_sync_ctrl: random payload around scripted sync patterns,
// a bit-index reference model feeding an event scoreboard, and a monitor
// that pops an expectation for every strobe or lock change the DUT shows.
module tb_frame_sync_ctrl;
  localparam int FRAME_LEN = 16;
  localparam int SYNC_W    = 8;
  localparam logic [7:0] SYNC_WORD = 8'hA7;
  localparam int LOCK_CNT  = 3;
  localparam int MISS_CNT  = 2;
  localparam int CW = $clog2(FRAME_LEN);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  frame_sync_if #(.FRAME_LEN(FRAME_LEN)) bus ();

  frame_sync_ctrl #(
    .FRAME_LEN(FRAME_LEN), .SYNC_W(SYNC_W), .SYNC_WORD(SYNC_WORD),
    .LOCK_CNT(LOCK_CNT), .MISS_CNT(MISS_CNT)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  // External counter_n: synchronous clear has priority over enable.
  always @(posedge clk) begin
    if (bus.cnt_sclr) bus.cnt_count <= '0;
    else if (bus.cnt_ce)
      bus.cnt_count <= (bus.cnt_count == CW'(FRAME_LEN - 1)) ? '0 : bus.cnt_count + CW'(1);
  end

  typedef struct { int idx; bit fs; bit se; bit lk; } ev_t;
  ev_t exp_q[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: alignment is an anchor bit index; checkpoints are every
  // FRAME_LEN valid bits after it.
  bit hist[$];
  int mk, anchor, hits, misses;
  bit mlk;

  function automatic void model_reset();
    hist.delete();
    mk = 0; anchor = -1; hits = 0; misses = 0; mlk = 0;
  endfunction

  function automatic void push_ev(input bit fs, input bit se, input bit lk);
    ev_t e;
    e.idx = mk; e.fs = fs; e.se = se; e.lk = lk;
    exp_q.push_back(e);
  endfunction

  function automatic void model_bit(input bit b);
    bit m;
    logic [7:0] w;
    hist.push_back(b);
    m = 0;
    if (hist.size() >= SYNC_W) begin
      w = '0;
      for (int i = 0; i < SYNC_W; i++) w = {w[6:0], hist[hist.size() - SYNC_W + i]};
      m = (w == SYNC_WORD);
    end
    if (hist.size() > SYNC_W) void'(hist.pop_front());
    if (anchor < 0) begin
      if (m) begin
        anchor = mk; hits = 1;
        if (LOCK_CNT == 1) begin mlk = 1; misses = 0; push_ev(1, 0, 1); end
      end
    end else if ((mk - anchor) % FRAME_LEN == 0) begin
      if (!mlk) begin
        if (m) begin
          hits++;
          if (hits == LOCK_CNT) begin mlk = 1; misses = 0; push_ev(1, 0, 1); end
        end else begin
          anchor = -1; hits = 0;
        end
      end else if (m) begin
        misses = 0; push_ev(1, 0, 1);
      end else begin
        misses++;
        if (misses == MISS_CNT) begin
          mlk = 0; anchor = -1; hits = 0; misses = 0; push_ev(0, 1, 0);
        end else begin
          push_ev(1, 1, 1);
        end
      end
    end
    mk++;
  endfunction

  // Monitor: valid-bit index of the most recently sampled bit.
  int mon_vb   = 0;
  int mon_last = -1;
  bit prev_lk  = 0;
  ev_t me;

  always @(posedge clk) begin
    if (!rst_n) mon_vb = 0;
    else if (bus.din_vld) begin mon_last = mon_vb; mon_vb++; end
  end

  always @(negedge clk) begin
    if (!rst_n) prev_lk = 0;
    else if (bus.frame_start || bus.sync_err || (bus.locked != prev_lk)) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_event: fs=%0d se=%0d lk=%0d idx=%0d, none expected",
                 bus.frame_start, bus.sync_err, bus.locked, mon_last);
      end else begin
        me = exp_q.pop_front();
        chk("ev_idx", mon_last, me.idx);
        chk("ev_frame_start", bus.frame_start, me.fs);
        chk("ev_sync_err", bus.sync_err, me.se);
        chk("ev_locked", bus.locked, me.lk);
        chk("ev_cnt_zero", bus.cnt_count, 0);
      end
      prev_lk = bus.locked;
    end
  end

  // Stimulus
  bit gap_mode = 0;
  int gap_cnt  = 0;

  task automatic step(input bit b, input bit v);
    bus.din = b; bus.din_vld = v;
    #1;
    chk("cnt_sclr", bus.cnt_sclr, (anchor < 0));
    chk("cnt_ce", bus.cnt_ce, (v && anchor >= 0));
    if (v) model_bit(b);
    @(posedge clk); #1;
  endtask

  task automatic send_bit(input bit b);
    gap_cnt++;
    if (gap_mode && (gap_cnt % 3 == 0)) step(1'($urandom_range(0, 1)), 1'b0);
    step(b, 1'b1);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_rand(input int n);
    for (int i = 0; i < n; i++) send_bit(1'($urandom_range(0, 1)));
  endtask

  task automatic send_frame(input logic [7:0] s);
    send_byte(s);
    send_rand(8);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    bus.din_vld = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst_locked", bus.locked, 0);
    chk("rst_frame_start", bus.frame_start, 0);
    chk("rst_sync_err", bus.sync_err, 0);
    chk("rst_cnt_sclr", bus.cnt_sclr, 1);
    chk("rst_cnt_ce", bus.cnt_ce, 0);
    repeat (3) @(posedge clk);
    chk("pending_at_reset", exp_q.size(), 0);
    exp_q.delete();
    model_reset();
    bus.din_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("cnt_after_reset", bus.cnt_count, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    bus.din = 1'b0;
    bus.din_vld = 1'b0;
    model_reset();

    // Clean acquisition, single miss, double miss.
    do_reset();
    send_rand(5);
    repeat (3) send_frame(SYNC_WORD);
    chk("locked_after_acq", bus.locked, mlk);
    repeat (2) send_frame(SYNC_WORD);
    send_frame(8'hA6);
    chk("locked_after_one_miss", bus.locked, 1);
    repeat (2) send_frame(SYNC_WORD);
    send_frame(8'hA6);
    send_frame(8'hA6);
    chk("locked_after_two_miss", bus.locked, 0);

    // Offset sync during VERIFY with the on-time sync corrupted.
    send_byte(SYNC_WORD);
    send_rand(5);
    send_byte(SYNC_WORD);
    repeat (3) send_bit(1'b0);
    repeat (3) send_frame(SYNC_WORD);
    send_frame(SYNC_WORD);
    chk("locked_after_reacq", bus.locked, mlk);

    // Same acquisition with DIN_VLD gaps, then reset mid-frame.
    do_reset();
    gap_mode = 1;
    send_rand(5);
    repeat (4) send_frame(SYNC_WORD);
    send_byte(SYNC_WORD);
    send_rand(3);
    chk("locked_before_reset", bus.locked, mlk);
    do_reset();
    gap_mode = 0;

    repeat (2) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
